// File: rtl/byte_deser_if.sv
// Byte-in / word-out handshake bundle for the byte deserializer.
interface byte_deser_if #(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 5
);
  logic [7:0]        in;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] dout;
  logic [CNT_W-1:0]  dout_bytecount;
  logic              dout_valid;
  logic              out_ready;
  logic              timeout_flag;

  modport master (
    output in, in_valid, in_last, out_ready,
    input  in_ready, dout, dout_bytecount,
    input  dout_valid, timeout_flag
  );

  modport slave (
    input  in, in_valid, in_last, out_ready,
    output in_ready, dout, dout_bytecount,
    output dout_valid, timeout_flag
  );
endinterface

// File: rtl/byte_deser.sv
// Byte deserializer: packs a valid/ready byte stream into wide words,
// emitting on in_last, on a full word, or after an idle timeout.
module byte_deser #(
  parameter int DATA_W       = 256,
  parameter int MAX_BYTES    = 32,
  parameter int CNT_W        = 5,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  byte_deser_if.slave  bus
);

  localparam int IW = $clog2(MAX_BYTES + 1);
  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(MAX_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_q, to_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic              accept;
  logic              full;
  logic              expire;
  logic              idle_run;

  assign bus.in_ready       = (state_q == COLLECT);
  assign bus.dout           = dout_q;
  assign bus.dout_bytecount = cnt_q;
  assign bus.dout_valid     = (state_q == HOLD);
  assign bus.timeout_flag   = to_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign full     = (idx_q == IDX_LAST);
  assign idle_run = (IDLE_TIMEOUT != 0) && (idx_q != '0);
  // Acceptance wins over a timeout landing in the same cycle.
  assign expire   = !accept && idle_run && (idle_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    idle_d  = idle_q;
    unique case (state_q)
      COLLECT: begin
        unique case (1'b1)
          accept: begin
            for (int i = 0; i < MAX_BYTES; i++) begin
              if (idx_q == IW'(i)) begin
                dout_d[8*i +: 8] = bus.in;
              end
            end
            idx_d  = idx_q + 1'b1;
            idle_d = '0;
            if (bus.in_last || full) begin
              state_d = HOLD;
              cnt_d   = idx_q[CNT_W-1:0];
              to_d    = 1'b0;
            end
          end
          expire: begin
            state_d = HOLD;
            cnt_d   = CNT_W'(idx_q - 1'b1);
            to_d    = 1'b1;
          end
          default: begin
            if (idle_run && idle_q != TO_LAST) begin
              idle_d = idle_q + 1'b1;
            end
          end
        endcase
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = COLLECT;
          dout_d  = '0;
          idx_d   = '0;
          idle_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      dout_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_byte_deser.sv
// Directed bench for byte_deser: vector table plus multi-cycle
// sequences for word cap, backpressure, idle timeout and async reset.
module tb_byte_deser;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  byte_deser_if #(.DATA_W(256), .CNT_W(5)) bus ();
  byte_deser_if #(.DATA_W(256), .CNT_W(5)) bus0 ();

  byte_deser #(
    .DATA_W(256), .MAX_BYTES(32), .CNT_W(5), .IDLE_TIMEOUT(64)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  byte_deser #(
    .DATA_W(256), .MAX_BYTES(32), .CNT_W(5), .IDLE_TIMEOUT(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  assign bus0.in        = bus.in;
  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_last   = bus.in_last;
  assign bus0.out_ready = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic drive(logic [7:0] b, logic v, logic l, logic o);
    @(negedge clk);
    bus.in        = b;
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = o;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.in        = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        l;
    logic        o;
    logic        ir;
    logic        dv;
    logic [4:0]  bc;
    logic [63:0] lo;
    logic        to;
  } vec_t;

  function automatic vec_t mk(logic [7:0] b, logic v, logic l, logic o,
                              logic ir, logic dv, logic [4:0] bc,
                              logic [63:0] lo, logic to);
    vec_t r;
    r.b = b; r.v = v; r.l = l; r.o = o;
    r.ir = ir; r.dv = dv; r.bc = bc; r.lo = lo; r.to = to;
    return r;
  endfunction

  vec_t vt[12];

  initial begin
    logic [255:0] e0, e1, w0, w1;
    logic [4:0]   bc0, bc1;
    int           idx, stalls, nw, first;
    logic         acc, seen0, tof;
    logic [255:0] tdout;
    logic [4:0]   tbc;

    vt[0]  = mk(8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
    vt[1]  = mk(8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
    vt[2]  = mk(8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
    vt[3]  = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2,
                64'h332211, 1'b0);
    vt[4]  = mk(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
    vt[5]  = mk(8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
    vt[6]  = mk(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
    vt[7]  = mk(8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
    vt[8]  = mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
    vt[9]  = mk(8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
    vt[10] = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4,
                64'h0504030201, 1'b0);
    vt[11] = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);

    reset         = 1'b1;
    bus.in        = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_dv", 256'(bus.dout_valid), 256'(0));
    check("rst_ir", 256'(bus.in_ready), 256'(1));
    check("rst_dout", bus.dout, 256'(0));
    check("rst_bc", 256'(bus.dout_bytecount), 256'(0));
    check("rst_to", 256'(bus.timeout_flag), 256'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].b, vt[i].v, vt[i].l, vt[i].o);
      check($sformatf("v%0d_ir", i), 256'(bus.in_ready), 256'(vt[i].ir));
      check($sformatf("v%0d_dv", i), 256'(bus.dout_valid),
            256'(vt[i].dv));
      if (vt[i].dv) begin
        check($sformatf("v%0d_bc", i), 256'(bus.dout_bytecount),
              256'(vt[i].bc));
        check($sformatf("v%0d_lo", i), 256'(bus.dout[63:0]),
              256'(vt[i].lo));
        check($sformatf("v%0d_hi", i), 256'(bus.dout[255:64]), 256'(0));
        check($sformatf("v%0d_to", i), 256'(bus.timeout_flag),
              256'(vt[i].to));
      end
    end

    e0 = '0;
    e1 = '0;
    for (int k = 0; k < 32; k++) e0[8*k +: 8] = 8'(k);
    for (int k = 0; k < 8; k++) e1[8*k +: 8] = 8'(32 + k);
    w0 = '0; w1 = '0; bc0 = '0; bc1 = '0;
    idx = 0; stalls = 0; nw = 0;
    for (int c = 0; c < 200 && !(idx == 40 && nw == 2); c++) begin
      drive(8'(idx), idx < 40, idx == 39, 1'b1);
      if (bus.dout_valid && nw == 0) begin
        w0 = bus.dout; bc0 = bus.dout_bytecount; nw++;
      end else if (bus.dout_valid && nw == 1) begin
        w1 = bus.dout; bc1 = bus.dout_bytecount; nw++;
      end
      if (!bus.in_ready && idx < 40) stalls++;
      acc = bus.in_ready && bus.in_valid;
      @(posedge clk);
      if (acc) idx++;
    end
    check("s40_sent", 256'(idx), 256'(40));
    check("s40_words", 256'(nw), 256'(2));
    check("s40_stall", 256'(stalls), 256'(1));
    check("s40_bc0", 256'(bc0), 256'(31));
    check("s40_w0", w0, e0);
    check("s40_bc1", 256'(bc1), 256'(7));
    check("s40_w1", w1, e1);

    do_reset();
    drive(8'hA5, 1'b1, 1'b1, 1'b0);
    check("bp_ir0", 256'(bus.in_ready), 256'(1));
    for (int k = 0; k < 10; k++) begin
      drive(8'h5A, 1'b1, 1'b1, 1'b0);
      check($sformatf("bp%0d_dv", k), 256'(bus.dout_valid), 256'(1));
      check($sformatf("bp%0d_ir", k), 256'(bus.in_ready), 256'(0));
      check($sformatf("bp%0d_dout", k), bus.dout, 256'h0A5);
      check($sformatf("bp%0d_bc", k), 256'(bus.dout_bytecount), 256'(0));
    end
    drive(8'h5A, 1'b1, 1'b1, 1'b1);
    check("bp_hand_dv", 256'(bus.dout_valid), 256'(1));
    check("bp_hand_ir", 256'(bus.in_ready), 256'(0));
    drive(8'h5A, 1'b1, 1'b1, 1'b1);
    check("bp_rel_dv", 256'(bus.dout_valid), 256'(0));
    check("bp_rel_ir", 256'(bus.in_ready), 256'(1));
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    check("bp_nxt_dv", 256'(bus.dout_valid), 256'(1));
    check("bp_nxt_dout", bus.dout, 256'h05A);
    check("bp_nxt_bc", 256'(bus.dout_bytecount), 256'(0));

    do_reset();
    drive(8'hDE, 1'b1, 1'b0, 1'b1);
    drive(8'hAD, 1'b1, 1'b0, 1'b1);
    first = -1; seen0 = 1'b0;
    tdout = '0; tbc = '0; tof = 1'b0;
    for (int k = 0; k < 100; k++) begin
      drive(8'h00, 1'b0, 1'b0, 1'b1);
      if (bus.dout_valid && first < 0) begin
        first = k;
        tdout = bus.dout; tbc = bus.dout_bytecount;
        tof = bus.timeout_flag;
      end
      if (bus0.dout_valid) seen0 = 1'b1;
    end
    check("to_edges", 256'(first), 256'(64));
    check("to_dout", tdout, 256'hADDE);
    check("to_bc", 256'(tbc), 256'(1));
    check("to_flag", 256'(tof), 256'(1));
    check("to0_none", 256'(seen0), 256'(0));

    do_reset();
    for (int k = 0; k < 5; k++) drive(8'(k + 1), 1'b1, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    check("ar_pre_dout", bus.dout, 256'h0504030201);
    #3;
    reset = 1'b1;
    #1;
    check("ar_dv", 256'(bus.dout_valid), 256'(0));
    check("ar_ir", 256'(bus.in_ready), 256'(1));
    check("ar_dout", bus.dout, 256'(0));
    check("ar_bc", 256'(bus.dout_bytecount), 256'(0));
    check("ar_to", 256'(bus.timeout_flag), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    drive(8'h7E, 1'b1, 1'b1, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    check("ar_new_dv", 256'(bus.dout_valid), 256'(1));
    check("ar_new_dout", bus.dout, 256'h07E);
    check("ar_new_bc", 256'(bus.dout_bytecount), 256'(0));
    check("ar_new_to", 256'(bus.timeout_flag), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/byte_deser.md
Name: byte_deser

Overview:
- Byte deserializer; the receive-side counterpart of the CPU's byte serializer.
- Accepts a byte stream with valid/ready handshake and packs up to MAX_BYTES bytes into one wide word.
- Presents the word with a byte count in the serializer's "count minus one" convention, so a packed word can be looped straight back into the serializer.
- Sits between the byte-wide link receiver and the CPU's wide data path.

Parameters:
- DATA_W, 256, output word width in bits; must equal 8*MAX_BYTES.
- MAX_BYTES, 32, bytes per word before a forced emit.
- CNT_W, 5, width of dout_bytecount; equals clog2(MAX_BYTES).
- IDLE_TIMEOUT, 64, cycles with no accepted byte before a partial word is emitted; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in  input  8  incoming byte.
- in_valid  input  1  byte on `in` is valid.
- in_last  input  1  byte is the final byte of its packet; qualified by in_valid.
- in_ready  output  1  block can accept a byte this cycle.
- dout  output  DATA_W  packed word; first received byte in dout[7:0], byte i in dout[8i+7:8i].
- dout_bytecount  output  CNT_W  number of valid bytes minus one.
- dout_valid  output  1  dout and dout_bytecount are valid.
- out_ready  input  1  consumer takes the word this cycle.
- timeout_flag  output  1  the current word was emitted by idle timeout (qualified by dout_valid).

Behaviour:
- Reset values (asynchronous): state=COLLECT, dout=0, byte index=0, dout_valid=0, dout_bytecount=0, timeout_flag=0, idle counter=0. In COLLECT, in_ready=1 is combinational.
- States: COLLECT, HOLD.
- in_ready=1 in COLLECT and 0 in HOLD; it is a function of state only.
- A byte is accepted when in_valid && in_ready.
- COLLECT, byte accepted:
  - byte written to lane[idx]; idx increments; idle counter clears.
  - Go to HOLD if in_last=1 or idx==MAX_BYTES-1 before the increment.
  - On that transition: dout_valid=1 next cycle, dout_bytecount=idx (pre-increment value), timeout_flag=0.
- COLLECT, no byte accepted:
  - If idx>0 and IDLE_TIMEOUT!=0, the idle counter increments.
  - When the counter reaches IDLE_TIMEOUT-1 while idx>0: go to HOLD with dout_bytecount=idx-1 and timeout_flag=1.
  - The idle counter does not run while idx==0.
- Latency: last byte accepted at edge N gives dout_valid high after edge N (visible in cycle N+1).
- HOLD:
  - dout, dout_bytecount and timeout_flag are held stable while dout_valid=1 and out_ready=0.
  - When out_ready=1: next cycle dout_valid=0, dout zeroed, idx=0, idle counter=0, state=COLLECT.
  - No byte is accepted in the handoff cycle, so worst-case throughput is MAX_BYTES bytes per MAX_BYTES+1 cycles.
- Unused upper lanes of an emitted word are 0.
- in_last asserted with in_valid=0 is ignored.
- A byte presented while in_ready=0 is not consumed; the upstream block holds it.
- Simultaneous last byte and MAX_BYTES boundary: a single emit; bytecount=MAX_BYTES-1.
- A timeout cannot coincide with byte acceptance: acceptance takes priority and clears the counter.
- Reset mid-word or mid-HOLD: the partial or held word is discarded; nothing is emitted.
- No overflow is possible: the MAX_BYTES cap forces an emit.
- Byte index and counter widths must not wrap; the counter saturates at its compare value.

Test Plan:
- 3-byte packet 0x11,0x22,0x33 (last on 0x33), out_ready=1 → one word: dout[23:0]=0x332211, upper bits 0, dout_bytecount=2, timeout_flag=0, dout_valid high for exactly 1 cycle.
- 40 bytes 0x00..0x27 in one stream, no in_last until byte 0x27, out_ready=1 →
  - word 1: 32 bytes 0x00..0x1F, bytecount=31;
  - in_ready low for 1 cycle;
  - word 2: bytes 0x20..0x27, bytecount=7.
- Backpressure: single byte 0xA5 with in_last, out_ready=0 for 10 cycles → dout_valid stays 1, dout/bytecount stable, in_ready=0, upstream byte 0x5A held until release; then 0x5A lands in lane 0 of the next word.
- Idle timeout (IDLE_TIMEOUT=64): 2 bytes 0xDE,0xAD then in_valid=0 → dout_valid rises 64 cycles after 0xAD was accepted; dout[15:0]=0xADDE, bytecount=1, timeout_flag=1. With IDLE_TIMEOUT=0, no emit ever occurs.
- Async reset mid-word after 5 bytes, asserted between clock edges → all outputs clear immediately. After release, a 1-byte packet 0x7E emits bytecount=0, dout=0x7E with no residue.
- in_last with in_valid=0 while idx=4 → no emit; the following valid byte continues the word.
